dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_word_array.sv | 33 +++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    // Byte address of word 0 when the instantiator does not override it.
    localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1ECE_B000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_rsp_state_t;

    // Only naturally aligned byte, halfword and word lane patterns are accepted.
    function automatic bit mask_legal(input logic [3:0] mask);
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100,
            4'b1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline MEM stage and the data memory.
interface dmem_responder_if;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;
    logic        busy;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err, busy
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err, busy
    );
endinterface

// File: rtl/dmem_word_array.sv
// Word array with per-byte write enables and a registered, write-first read port.
module dmem_word_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     we,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    // One byte-wide bank per lane so each lane maps onto a plain RAM template.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_reg;

        // Enabled access: written lanes return the new byte, others the stored byte.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                    rd_reg    <= wdata[gi*8 +: 8];
                end else begin
                    rd_reg    <= mem[addr];
                end
            end
        end

        assign rdata[gi*8 +: 8] = rd_reg;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one dmem request at a time, services it from
// the word array and answers with a one-cycle response after LATENCY cycles.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    dmem_responder_if.slave dmem
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_rsp_state_t state_reg;
    logic [3:0]      cnt_reg;
    logic            resp_reg;
    logic            err_reg;
    logic            busy_reg;
    logic            rd_valid_reg;
    logic            err_pend_reg;
    logic            rd_pend_reg;

    logic [31:0]     offset;
    logic            in_range;
    logic            is_read;
    logic            is_write;
    logic            malformed;
    logic            req_ok;
    logic            accept;
    logic [3:0]      array_we;
    logic [31:0]     array_rdata;

    // Request decode: word-aligned offset from the window base, wrapping modulo 2^32.
    always_comb begin
        offset    = (dmem.dmem_addr - BASE_ADDR) & ~32'h3;
        in_range  = {1'b0, offset} < SPAN;
        is_read   = |dmem.dmem_rmask;
        is_write  = |dmem.dmem_wmask;
        malformed = (is_read && is_write)
                 || (is_read  && !mask_legal(dmem.dmem_rmask))
                 || (is_write && !mask_legal(dmem.dmem_wmask));
        req_ok    = in_range && !malformed;
        accept    = (state_reg == IDLE) && (is_read || is_write);
        array_we  = (accept && req_ok) ? dmem.dmem_wmask : 4'b0000;
    end

    // The array port is only exercised on acceptance, so its read register
    // holds the captured word until the response is delivered.
    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .addr  (offset[AW+1:2]),
        .we    (array_we),
        .wdata (dmem.dmem_wdata),
        .rdata (array_rdata)
    );

    // Request FSM: accept in IDLE, count down in WAIT, pulse the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            resp_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            err_pend_reg <= 1'b0;
            rd_pend_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_reg     <= 1'b0;
                    err_reg      <= 1'b0;
                    rd_valid_reg <= 1'b0;
                    if (accept) begin
                        err_pend_reg <= !req_ok;
                        rd_pend_reg  <= req_ok && is_read;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state_reg    <= RESP;
                            resp_reg     <= 1'b1;
                            err_reg      <= !req_ok;
                            rd_valid_reg <= req_ok && is_read;
                        end else begin
                            state_reg    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg    <= RESP;
                        resp_reg     <= 1'b1;
                        err_reg      <= err_pend_reg;
                        rd_valid_reg <= rd_pend_reg;
                    end
                end
                RESP: begin
                    state_reg    <= IDLE;
                    resp_reg     <= 1'b0;
                    err_reg      <= 1'b0;
                    rd_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    resp_reg     <= 1'b0;
                    err_reg      <= 1'b0;
                    rd_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Read data is the captured word only for a successful read response.
    assign dmem.dmem_rdata = rd_valid_reg ? array_rdata : 32'h0;
    assign dmem.dmem_resp  = resp_reg;
    assign dmem.dmem_err   = err_reg;
    assign dmem.busy       = busy_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 3) with a
// 16-word window, scoreboard of expected responses, shadow memory per instance.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1ECE_B000;
    localparam int          WORDS = 16;
    localparam int          LAT_TAB [3] = '{2, 1, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] req_addr  [3];
    logic [3:0]  req_rmask [3];
    logic [3:0]  req_wmask [3];
    logic [31:0] req_wdata [3];
    logic [31:0] rdata_o   [3];
    logic        resp_o    [3];
    logic        err_o     [3];
    logic        busy_o    [3];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.dmem_addr  = req_addr[0];
    assign bus0.dmem_rmask = req_rmask[0];
    assign bus0.dmem_wmask = req_wmask[0];
    assign bus0.dmem_wdata = req_wdata[0];
    assign bus1.dmem_addr  = req_addr[1];
    assign bus1.dmem_rmask = req_rmask[1];
    assign bus1.dmem_wmask = req_wmask[1];
    assign bus1.dmem_wdata = req_wdata[1];
    assign bus2.dmem_addr  = req_addr[2];
    assign bus2.dmem_rmask = req_rmask[2];
    assign bus2.dmem_wmask = req_wmask[2];
    assign bus2.dmem_wdata = req_wdata[2];

    assign rdata_o[0] = bus0.dmem_rdata;
    assign resp_o[0]  = bus0.dmem_resp;
    assign err_o[0]   = bus0.dmem_err;
    assign busy_o[0]  = bus0.busy;
    assign rdata_o[1] = bus1.dmem_rdata;
    assign resp_o[1]  = bus1.dmem_resp;
    assign err_o[1]   = bus1.dmem_err;
    assign busy_o[1]  = bus1.busy;
    assign rdata_o[2] = bus2.dmem_rdata;
    assign resp_o[2]  = bus2.dmem_resp;
    assign err_o[2]   = bus2.dmem_err;
    assign busy_o[2]  = bus2.busy;

    dmem_responder #(.DEPTH_WORDS(WORDS), .LATENCY(2), .BASE_ADDR(BASE)) u_dut0 (
        .clk (clk), .rst (rst), .dmem (bus0.slave));
    dmem_responder #(.DEPTH_WORDS(WORDS), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk (clk), .rst (rst), .dmem (bus1.slave));
    dmem_responder #(.DEPTH_WORDS(WORDS), .LATENCY(3), .BASE_ADDR(BASE)) u_dut2 (
        .clk (clk), .rst (rst), .dmem (bus2.slave));

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt [3] = '{0, 0, 0};
    int          issued   [3] = '{0, 0, 0};
    int          last_resp_cyc [3];
    logic [31:0] model_mem [3][WORDS];
    logic [31:0] last_rdata;
    logic        last_err;
    exp_t        sb [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resp_o[i] === 1'b1) resp_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_lanes_ok(input logic [3:0] m);
        return m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    // Drives one request on instance d (called at a negedge), waits for the
    // response, checks it against the scoreboard, then releases the request.
    task automatic do_req(input int d, input logic [31:0] addr, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] off;
        logic        bad;
        int          n;
        bit          got;
        bit          busy_ok;
        off = {addr[31:2], 2'b00} - BASE;
        bad = (rm != 0 && wm != 0) || (rm != 0 && !exp_lanes_ok(rm))
           || (wm != 0 && !exp_lanes_ok(wm)) || (off >= 32'(WORDS * 4));
        e.err   = bad;
        e.lat   = LAT_TAB[d];
        e.rdata = (!bad && rm != 0) ? model_mem[d][off[5:2]] : 32'h0;
        if (!bad && wm != 0) begin
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) model_mem[d][off[5:2]][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        sb.push_back(e);
        issued[d]++;
        req_addr[d]  = addr;
        req_rmask[d] = rm;
        req_wmask[d] = wm;
        req_wdata[d] = wd;
        n = 0;
        got = 0;
        busy_ok = 1;
        while (n < 40 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy_o[d] !== 1'b1) busy_ok = 0;
            if (resp_o[d] === 1'b1) got = 1;
        end
        check("resp_seen", 32'(got), 32'd1);
        got_e = sb.pop_front();
        last_rdata = rdata_o[d];
        last_err   = err_o[d];
        last_resp_cyc[d] = cyc;
        if (got) begin
            check("latency", n, got_e.lat);
            check("busy_during", 32'(busy_ok), 32'd1);
            check("sb_rdata", rdata_o[d], got_e.rdata);
            check("sb_err", 32'(err_o[d]), 32'(got_e.err));
        end
        @(posedge clk);
        @(negedge clk);
        req_rmask[d] = 4'h0;
        req_wmask[d] = 4'h0;
        check("resp_single", 32'(resp_o[d]), 32'd0);
        check("busy_after", 32'(busy_o[d]), 32'd0);
        $display("txn dut%0d addr=%08h rm=%h wm=%h wd=%08h -> rdata=%08h err=%0b lat=%0d",
                 d, addr, rm, wm, wd, last_rdata, last_err, n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = BASE;
            req_rmask[d] = 4'h0;
            req_wmask[d] = 4'h0;
            req_wdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata_o[0], 32'h0);
        check("rst_resp", 32'(resp_o[0]), 32'd0);
        check("rst_err", 32'(err_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy_o[0]), 32'd0);

        // Known contents for every word of instance 0.
        for (int i = 0; i < WORDS; i++)
            do_req(0, BASE + 32'(i * 4), 4'h0, 4'hF, 32'hC3C3_0000 ^ (32'(i) * 32'h1111_1111));

        // Full-word write and readback.
        do_req(0, BASE + 32'h10, 4'h0, 4'hF, 32'hDEAD_BEEF);
        do_req(0, BASE + 32'h10, 4'hF, 4'h0, 32'h0);
        check("rd_full", last_rdata, 32'hDEAD_BEEF);
        check("rd_full_err", 32'(last_err), 32'd0);

        // Byte and halfword merges.
        do_req(0, BASE + 32'h10, 4'h0, 4'b0100, 32'h00AB_0000);
        do_req(0, BASE + 32'h10, 4'hF, 4'h0, 32'h0);
        check("merge_byte", last_rdata, 32'hDEAB_BEEF);
        do_req(0, BASE + 32'h10, 4'h0, 4'b1100, 32'h1234_0000);
        do_req(0, BASE + 32'h10, 4'hF, 4'h0, 32'h0);
        check("merge_half", last_rdata, 32'h1234_BEEF);
        do_req(0, BASE + 32'h13, 4'b0001, 4'h0, 32'h0);
        check("addr_low_bits", last_rdata, 32'h1234_BEEF);

        // Out-of-range reads and writes on both sides of the window.
        do_req(0, BASE - 32'h4, 4'hF, 4'h0, 32'h0);
        check("oor_lo_err", 32'(last_err), 32'd1);
        check("oor_lo_rdata", last_rdata, 32'h0);
        do_req(0, BASE + 32'(WORDS * 4), 4'hF, 4'h0, 32'h0);
        check("oor_hi_err", 32'(last_err), 32'd1);
        do_req(0, BASE + 32'(WORDS * 4), 4'h0, 4'hF, 32'hFFFF_FFFF);
        do_req(0, BASE - 32'h4, 4'h0, 4'hF, 32'hFFFF_FFFF);
        check("oor_wr_err", 32'(last_err), 32'd1);

        // Malformed requests.
        do_req(0, BASE + 32'h10, 4'b0001, 4'b0001, 32'hFFFF_FFFF);
        check("bad_both_err", 32'(last_err), 32'd1);
        do_req(0, BASE + 32'h10, 4'h0, 4'b0101, 32'hFFFF_FFFF);
        check("bad_mask_err", 32'(last_err), 32'd1);

        // Every in-range word still matches the shadow copy.
        for (int i = 0; i < WORDS; i++)
            do_req(0, BASE + 32'(i * 4), 4'hF, 4'h0, 32'h0);
        check("post_bad_word4", last_rdata, model_mem[0][WORDS-1]);

        // Back-to-back requests on the LATENCY=1 and LATENCY=3 instances.
        for (int d = 1; d < 3; d++) begin
            do_req(d, BASE + 32'h8, 4'h0, 4'hF, 32'h1122_3344 + 32'(d));
            for (int k = 0; k < 3; k++) begin
                snap = last_resp_cyc[d];
                do_req(d, BASE + 32'h8, 4'hF, 4'h0, 32'h0);
                check("period", last_resp_cyc[d] - snap, LAT_TAB[d] + 1);
                check("b2b_rdata", last_rdata, 32'h1122_3344 + 32'(d));
            end
        end

        // Reset during WAIT abandons the read; contents survive.
        snap = resp_cnt[0];
        req_addr[0]  = BASE + 32'h10;
        req_rmask[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("wait_busy", 32'(busy_o[0]), 32'd1);
        rst = 1'b1;
        req_rmask[0] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abandoned_resp", resp_cnt[0], snap);
        do_req(0, BASE + 32'h10, 4'hF, 4'h0, 32'h0);
        check("retained", last_rdata, 32'h1234_BEEF);

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check("resp_count", resp_cnt[d], issued[d]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
